// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser, one-cycle edge pulse,
// sticky flag and saturating edge counter, with a common edge-select mode.
module edge_detect_multi #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       sig,
  input  logic [1:0]          mode,
  input  logic                clr,
  output logic [CH-1:0]       pulse,
  output logic [CH-1:0]       sticky,
  output logic [CH*CNT_W-1:0] count,
  output logic                any
);

  localparam int unsigned WARM_LOAD = SYNC_STAGES + 1;
  localparam int unsigned WARM_W    = $clog2(WARM_LOAD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CH-1:0]     sync_q [SYNC_STAGES];
  logic [CH-1:0]     hist;
  logic [WARM_W-1:0] warm;
  logic [CNT_W-1:0]  cnt_q [CH];
  logic [CH-1:0]     rise_c;
  logic [CH-1:0]     fall_c;
  logic [CH-1:0]     edge_c;

  // Synchroniser chain plus one history stage behind its last flop
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      hist <= '0;
    end else begin
      sync_q[0] <= sig;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      hist <= sync_q[SYNC_STAGES-1];
    end
  end

  // Warm-up countdown: blocks detection until the chain holds post-reset samples
  always_ff @(posedge clk) begin
    if (rst) begin
      warm <= WARM_W'(WARM_LOAD);
    end else if (warm != '0) begin
      warm <= warm - WARM_W'(1);
    end
  end

  // Edge decision from the synchronised level and its history, gated by mode
  always_comb begin
    rise_c = sync_q[SYNC_STAGES-1] & ~hist;
    fall_c = ~sync_q[SYNC_STAGES-1] & hist;
    edge_c = '0;
    if (warm == '0) begin
      edge_c = ({CH{mode[0]}} & rise_c) | ({CH{mode[1]}} & fall_c);
    end
  end

  // Registered pulse and its OR, aligned in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= '0;
      any   <= 1'b0;
    end else begin
      pulse <= edge_c;
      any   <= |edge_c;
    end
  end

  // Sticky flags: a coincident edge beats clr
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= '0;
    end else if (clr) begin
      sticky <= edge_c;
    end else begin
      sticky <= sticky | edge_c;
    end
  end

  // Saturating counters: edge with clr restarts at one, clr alone zeroes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (edge_c[i]) begin
          if (clr) begin
            cnt_q[i] <= CNT_W'(1);
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else if (clr) begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_count
    assign count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench for edge_detect_multi: directed scenarios then random traffic,
// checked against a sample-history reference model.
module tb_edge_detect_multi;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [CH-1:0]  sig;
  logic [1:0]     mode;
  logic           clr;
  logic [CH-1:0]  pulse;
  logic [CH-1:0]  sticky;
  logic [CH*CW-1:0] count;
  logic           any;

  edge_detect_multi #(.CH(CH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sig(sig), .mode(mode), .clr(clr),
    .pulse(pulse), .sticky(sticky), .count(count), .any(any)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int pulse_events = 0;
  int pulses2 = 0;

  // reference model state
  int            n;
  logic [CH-1:0] smp[$];
  logic [CH-1:0] m_pulse;
  logic          m_any;
  logic [CH-1:0] m_sticky;
  int            m_cnt [CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Level seen at the sync output at posedge n is sig sampled at posedge n-SS;
  // an edge is a change versus the sample one posedge earlier.
  task automatic model_update();
    logic [CH-1:0] cur, prev, e;
    if (rst) begin
      n = 0;
      smp.delete();
      m_pulse = '0; m_any = 1'b0; m_sticky = '0;
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    end else begin
      n++;
      smp.push_back(sig);
      cur  = (n >= SS + 1) ? smp[n-SS-1] : '0;
      prev = (n >= SS + 2) ? smp[n-SS-2] : '0;
      e = '0;
      if (n > SS + 1) begin
        for (int i = 0; i < CH; i++)
          e[i] = (mode[0] && cur[i] && !prev[i]) || (mode[1] && !cur[i] && prev[i]);
      end
      m_pulse = e;
      m_any = |e;
      m_sticky = clr ? e : (m_sticky | e);
      for (int i = 0; i < CH; i++) begin
        if (e[i]) m_cnt[i] = clr ? 1 : ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX);
        else if (clr) m_cnt[i] = 0;
      end
    end
  endtask

  task automatic step();
    logic [CH*CW-1:0] ec;
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < CH; i++) ec[i*CW +: CW] = CW'(m_cnt[i]);
    chk("pulse", 32'(pulse), 32'(m_pulse));
    chk("any", 32'(any), 32'(m_any));
    chk("sticky", 32'(sticky), 32'(m_sticky));
    chk("count", 32'(count), 32'(ec));
    if (pulse != '0) pulse_events++;
    if (pulse[2]) pulses2++;
  endtask

  initial begin
    rst = 1'b1; sig = 4'hF; mode = 2'b11; clr = 1'b0;

    // 1: reset with all lines high, no pulse through warm-up
    step(); step();
    rst = 1'b0;
    pulse_events = 0;
    repeat (6) step();
    chk("t1_no_pulse", 32'(pulse_events), 32'd0);
    chk("t1_count", 32'(count), 32'h0);
    chk("t1_sticky", 32'(sticky), 32'h0);

    // 2: falling edge on ch0, pulse after exactly two more clocks
    mode = 2'b10; sig = 4'hE;
    step(); chk("t2_n0", 32'(pulse), 32'h0);
    step(); chk("t2_n1", 32'(pulse), 32'h0);
    step();
    chk("t2_pulse", 32'(pulse), 32'h1);
    chk("t2_any", 32'(any), 32'h1);
    chk("t2_cnt0", 32'(count[3:0]), 32'h1);
    chk("t2_sticky", 32'(sticky), 32'h1);
    step(); chk("t2_one_cycle", 32'(pulse), 32'h0);

    // 3: both edges, 20 toggles on ch2, counter saturates
    mode = 2'b11; pulses2 = 0;
    for (int i = 0; i < 20; i++) begin
      sig[2] = ~sig[2];
      step(); step();
    end
    repeat (3) step();
    chk("t3_pulses", 32'(pulses2), 32'd20);
    chk("t3_sat", 32'(count[11:8]), 32'd15);

    // 4: rising only, all channels rise together, falls ignored
    clr = 1'b1; step(); clr = 1'b0;
    chk("t4_clr_cnt", 32'(count), 32'h0);
    chk("t4_clr_sticky", 32'(sticky), 32'h0);
    mode = 2'b01; sig = 4'h0;
    repeat (4) step();
    chk("t4_fall_ignored", 32'(count), 32'h0);
    sig = 4'hF;
    step(); step(); chk("t4_early", 32'(pulse), 32'h0);
    step(); chk("t4_pulse", 32'(pulse), 32'hF);
    step(); chk("t4_once", 32'(pulse), 32'h0);
    chk("t4_counts", 32'(count), 32'h1111);
    sig = 4'h0;
    repeat (4) step();
    chk("t4_counts_hold", 32'(count), 32'h1111);
    chk("t4_sticky", 32'(sticky), 32'hF);

    // 5: clr coincident with a ch1 pulse
    mode = 2'b11; sig = 4'h2;
    step(); step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("t5_pulse", 32'(pulse), 32'h2);
    chk("t5_sticky", 32'(sticky), 32'h2);
    chk("t5_count", 32'(count), 32'h0010);
    step();

    // 6: reset while an edge is in the sync chain
    sig = 4'h0;
    step();
    rst = 1'b1; step();
    chk("t6_pulse", 32'(pulse), 32'h0);
    chk("t6_count", 32'(count), 32'h0);
    chk("t6_any", 32'(any), 32'h0);
    rst = 1'b0; pulse_events = 0;
    repeat (6) step();
    chk("t6_no_pulse", 32'(pulse_events), 32'd0);
    sig = 4'h8;
    step(); step(); step();
    chk("t6_after", 32'(pulse), 32'h8);
    chk("t6_after_cnt", 32'(count), 32'h1000);

    // 7: random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 19) == 0);
      if ((c % 16) == 0) mode = 2'($urandom_range(0, 3));
      sig = sig ^ (4'($urandom) & 4'($urandom));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
